fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 85 ++++++++
 tb/tb_fetch_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller. Issues one RAM read per instruction, captures the
// returned word in ir and holds it until the decoder takes it or a jump redirects.
module fetch_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  iAddr,
  output logic               FETCH,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               fetch_q, valid_q, busy_q;
  logic               handshake;

  assign handshake = valid_q & ir_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    // A jump overrides everything; ir is left untouched so an in-flight word is dropped.
    if (jump) begin
      pc_d    = jump_addr;
      state_d = (state_q == IDLE && !start) ? IDLE : REQ;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = REQ;
        REQ:  state_d = WAIT;
        WAIT: begin
          ir_d    = instr;
          state_d = HOLD;
        end
        HOLD: if (handshake) begin
          pc_d    = pc_q + 1'b1;
          state_d = halt ? IDLE : REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      fetch_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fetch_q <= (state_d == REQ);
      valid_q <= (state_d == HOLD);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign iAddr    = pc_q;
  assign pc       = pc_q;
  assign FETCH    = fetch_q;
  assign ir       = ir_q;
  assign ir_valid = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random stimulus, checked against a
// phase-counting reference model with a scoreboard of expected handshakes.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, halt = 1'b0, jump = 1'b0, ir_ready = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic [7:0] iAddr, ir, pc;
  logic [7:0] instr = 8'h00;
  logic       FETCH, ir_valid, busy;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  int          checks = 0, errors = 0, n_hs = 0;

  // Reference model: phase -1 = idle, 0 = read issued, 1 = data returning, 2 = presenting.
  int         phase = -1;
  logic [7:0] m_pc  = 8'h00;
  bit         take  = 1'b0;

  fetch_ctrl #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .jump(jump),
    .jump_addr(jump_addr), .iAddr(iAddr), .FETCH(FETCH), .instr(instr),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .pc(pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Instruction RAM with one-cycle registered read.
  always @(posedge clk) if (FETCH) instr <= mem[iAddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic st, input logic hl, input logic jp,
                     input logic [7:0] ja, input logic rdy);
    @(posedge clk); #1;
    start = st; halt = hl; jump = jp; jump_addr = ja; ir_ready = rdy;
  endtask

  task automatic async_reset();
    @(posedge clk); #1;
    start = 0; halt = 0; jump = 0; ir_ready = 0;
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Model update at the clock edge; the handshake decision is taken at negedge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        phase = -1;
        m_pc  = 8'h00;
      end else if (jump) begin
        m_pc  = jump_addr;
        phase = (phase == -1 && !start) ? -1 : 0;
      end else if (phase == -1) begin
        if (start) phase = 0;
      end else if (phase < 2) begin
        phase = phase + 1;
      end else if (take) begin
        m_pc  = m_pc + 8'd1;
        phase = halt ? -1 : 0;
      end
      @(negedge clk);
      take = !rst && phase == 2 && ir_ready;
      if (take) exp_q.push_back({m_pc, mem[m_pc]});
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on every DUT handshake.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        chk("rst_fetch", FETCH, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
      end else begin
        chk("fetch", FETCH, phase == 0);
        chk("ir_valid", ir_valid, phase == 2);
        chk("busy", busy, phase != -1);
        chk("pc", pc, m_pc);
        chk("iaddr", iAddr, m_pc);
        if (ir_valid) chk("ir_hold", ir, mem[m_pc]);
        if (ir_valid && ir_ready) begin
          n_hs++;
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_hs", 1, 0);
          end else begin
            e = exp_q.pop_front();
            $display("hs pc=0x%02h ir=0x%02h exp_pc=0x%02h exp_ir=0x%02h", pc, ir, e[15:8], e[7:0]);
            chk("sb_pc", pc, e[15:8]);
            chk("sb_ir", ir, e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic sequencing from reset.
    cyc(1, 0, 0, 8'h00, 1);
    repeat (9) cyc(0, 0, 0, 8'h00, 1);
    // Decoder stall.
    repeat (5) cyc(0, 0, 0, 8'h00, 0);
    repeat (4) cyc(0, 0, 0, 8'h00, 1);
    // Jumps landing in each busy phase.
    for (int k = 0; k < 3; k++) begin
      repeat (k + 1) cyc(0, 0, 0, 8'h00, 1);
      cyc(0, 0, 1, 8'h40 + 8'(k), 1);
    end
    repeat (6) cyc(0, 0, 0, 8'h00, 1);
    // PC wrap.
    cyc(0, 0, 1, 8'hFE, 1);
    repeat (12) cyc(0, 0, 0, 8'h00, 1);
    // Halt at pc=5, then stay idle.
    cyc(0, 0, 1, 8'h05, 1);
    repeat (4) cyc(0, 1, 0, 8'h00, 1);
    repeat (6) cyc(0, 0, 0, 8'h00, 1);
    // Jump while idle without start, then start at the new pc.
    cyc(0, 0, 1, 8'h80, 1);
    repeat (2) cyc(0, 0, 0, 8'h00, 1);
    cyc(1, 0, 0, 8'h00, 1);
    repeat (7) cyc(0, 0, 0, 8'h00, 1);
    // Asynchronous reset during a fetch.
    cyc(1, 1, 0, 8'h00, 1);
    repeat (4) cyc(1, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    async_reset();
    repeat (4) cyc(0, 0, 0, 8'h00, 1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) async_reset();
      else cyc($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
               8'($urandom), $urandom_range(3) != 0);
    end

    // Drain: halt on the next handshake, then settle.
    repeat (8) cyc(0, 1, 0, 8'h00, 1);
    repeat (3) cyc(0, 0, 0, 8'h00, 1);
    @(negedge clk); #2;
    chk("sb_leftover", exp_q.size(), 0);
    chk("enough_handshakes", n_hs >= 50, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
